rsa_word_frontend: RTL and testbench
====================================

# rsa_word_frontend

Word-serial host frontend for the modular-exponentiation core. It accepts 32-bit command/data words over a valid/ready stream and assembles the 1024-bit operands (message, modulus, R mod N, R² mod N) and the 16-bit exponent. It then pulses the core start, captures the 1024-bit result on the core's one-cycle done pulse, and streams the result back as 32 words. It sits directly upstream and downstream of `montgomery_exp`, between the bus/DMA interface and the core.

## Interface
- `WORD_W`, 32, stream word width; fixed, only 32 supported.
- `OP_W`, 1024, operand width; words per operand `NW = OP_W/WORD_W` = 32.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low; clock `clk`.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  frontend accepts a word this cycle.
- `s_data`  in  32  input word.
- `m_valid`  out  1  result word valid.
- `m_ready`  in  1  downstream accepts a result word.
- `m_data`  out  32  result word, least-significant word first.
- `m_last`  out  1  high with the 32nd result word.
- `core_msg`, `core_n`, `core_rmodn`, `core_r2modn`  out  1024 each  operand registers.
- `core_exp`  out  16  exponent register.
- `core_encryp_mode`  out  1  mode latched from the start header.
- `core_start`  out  1  single-cycle start pulse to the core.
- `core_done`  in  1  core completion pulse; one cycle wide.
- `core_result`  in  1024  core result; valid only in the `core_done` cycle.
- `busy`  out  1  high in states other than IDLE.
- `err`  out  1  sticky illegal-header flag.

## Operation
- Transfer rules: an input transfer occurs when `s_valid && s_ready`; an output transfer occurs when `m_valid && m_ready`.
- Header word: `s_data[2:0]` is the opcode; `s_data[3]` is the mode (used by START only); all other bits are ignored.
- Opcodes:
  - 0 = MSG, 1 = N, 2 = RMODN, 3 = R2MODN: each is followed by 32 data words.
  - 4 = EXP: followed by 1 data word; `core_exp <= s_data[15:0]`.
  - 5 = START: no data words.
  - 6, 7 = illegal.
- FSM states and transitions:
  - IDLE: `s_ready`=1. Opcodes 0–3 go to LOAD with word counter = 0. Opcode 4 goes to LOADEXP. Opcode 5 goes to RUN; it latches `core_encryp_mode`, clears `err`, and asserts `core_start`. Opcodes 6/7 set `err` and stay in IDLE; the word is consumed.
  - LOAD: `s_ready`=1. Each accepted word updates the target register as `reg <= {s_data, reg[OP_W-1:WORD_W]}`, so the first word ends in bits [31:0]. After the 32nd word (counter = 31), go to IDLE.
  - LOADEXP: `s_ready`=1. One word is accepted, then go to IDLE.
  - RUN: `s_ready`=0. Operand outputs are held stable. On `core_done`, load `core_result` into the output shift register and go to DRAIN.
  - DRAIN: `s_ready`=0, `m_valid`=1, `m_data` = out_reg[31:0]. On each output transfer, shift out_reg right by 32 and increment the counter. `m_last` = (counter == 31). After the last transfer, go to IDLE.
- `core_done` is ignored outside RUN.
- Operand registers are not modified outside LOAD/LOADEXP. They may be reloaded individually between runs; START reuses the current values.
- The word counter is 5 bits and wraps only through the state exit. It is shared by LOAD and DRAIN.

## Timing
- Reset values:
  - All operand registers, `core_exp`, `core_encryp_mode`, `m_data` = 0.
  - `core_start`=0, `m_valid`=0, `m_last`=0, `busy`=0, `err`=0.
  - `s_ready`=1 from the first cycle after reset release.
- Reset mid-operation: any state returns to IDLE on the next edge, and all registers take their reset values. A pending core run is abandoned; `core_done` arriving afterwards is ignored.
- START header accepted at edge T: `core_start`=1 during cycle T+1 only; `busy`=1 from T+1.
- A loaded operand word is visible on its `core_*` output the cycle after acceptance.
- `core_done` sampled high at edge D: `m_valid`=1 and word 0 on `m_data` from D+1.
- With `m_ready` held high, the 32 words take 32 consecutive cycles. `s_ready`=1 the cycle after the last output transfer.
- Backpressure: while `m_valid && !m_ready`, `m_data` and `m_last` hold.
- Throughput: an operand frame takes at least 33 cycles; EXP takes 2; START takes 1.

## Test plan
- Load MSG with words k=0..31 equal to 0x1000_0000+k: `core_msg[32k+31:32k]` = 0x1000_0000+k. Verify 33 accepted cycles, `s_ready` continuously 1, and other operands unchanged.
- EXP header then 0xABCD_0011: `core_exp` = 16'h0011. START header with bit 3 = 1: `core_encryp_mode`=1, exactly one `core_start` cycle, `s_ready`=0 until the drain ends.
- Stub core returns `core_done` 10 cycles after start with result word k = ~k, and `m_ready` toggles every cycle: 32 words appear in order, `m_last` only on word 31, data stable while stalled.
- Header 0x7: `err`=1, state stays IDLE. A following START clears `err` to 0.
- Assert `resetn`=0 after 12 words of an N frame: all outputs return to reset values, `core_n`=0, and a new full N frame then loads correctly.
- `core_done` pulsed while in IDLE and during LOAD: no `m_valid`, no state change.

Source files
------------

// File: rtl/rsa_word_frontend.sv
// Word-serial host frontend for montgomery_exp: assembles operands from 32-bit words, starts the core, streams the result LSW first.
// Loaded words are visible one cycle after acceptance; s_ready drops for the whole run/drain; m_data/m_last hold while m_ready is low.
module rsa_word_frontend #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 1024
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic [OP_W-1:0]   core_msg,
   output logic [OP_W-1:0]   core_n,
   output logic [OP_W-1:0]   core_rmodn,
   output logic [OP_W-1:0]   core_r2modn,
   output logic [15:0]       core_exp,
   output logic              core_encryp_mode,
   output logic              core_start,
   input  logic              core_done,
   input  logic [OP_W-1:0]   core_result,
   output logic              busy,
   output logic              err
);

   localparam logic [4:0] LAST_IDX = 5'(OP_W / WORD_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADEXP, S_RUN, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [1:0]      tgt_q, tgt_d;
   logic [OP_W-1:0] msg_q, msg_d, n_q, n_d, rmodn_q, rmodn_d, r2modn_q, r2modn_d;
   logic [OP_W-1:0] out_q, out_d;
   logic [15:0]     exp_q, exp_d;
   logic            mode_q, mode_d, start_q, start_d, err_q, err_d;
   logic            s_fire, m_fire;

   assign s_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_LOADEXP);
   assign m_valid = (state_q == S_DRAIN);
   assign m_data  = out_q[WORD_W-1:0];
   assign m_last  = m_valid && (cnt_q == LAST_IDX);
   assign busy    = (state_q != S_IDLE);
   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;

   assign core_msg         = msg_q;
   assign core_n           = n_q;
   assign core_rmodn       = rmodn_q;
   assign core_r2modn      = r2modn_q;
   assign core_exp         = exp_q;
   assign core_encryp_mode = mode_q;
   assign core_start       = start_q;
   assign err              = err_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tgt_d    = tgt_q;
      msg_d    = msg_q;
      n_d      = n_q;
      rmodn_d  = rmodn_q;
      r2modn_d = r2modn_q;
      out_d    = out_q;
      exp_d    = exp_q;
      mode_d   = mode_q;
      err_d    = err_q;
      start_d  = 1'b0;
      case (state_q)
         S_IDLE: if (s_fire) begin
            case (s_data[2:0])
               3'd0, 3'd1, 3'd2, 3'd3: begin
                  tgt_d   = s_data[1:0];
                  cnt_d   = 5'd0;
                  state_d = S_LOAD;
               end
               3'd4: state_d = S_LOADEXP;
               3'd5: begin
                  mode_d  = s_data[3];
                  err_d   = 1'b0;
                  start_d = 1'b1;
                  state_d = S_RUN;
               end
               default: err_d = 1'b1;
            endcase
         end
         S_LOAD: if (s_fire) begin
            // Shift in from the top so the first word lands in bits [31:0].
            case (tgt_q)
               2'd0:    msg_d    = {s_data, msg_q[OP_W-1:WORD_W]};
               2'd1:    n_d      = {s_data, n_q[OP_W-1:WORD_W]};
               2'd2:    rmodn_d  = {s_data, rmodn_q[OP_W-1:WORD_W]};
               default: r2modn_d = {s_data, r2modn_q[OP_W-1:WORD_W]};
            endcase
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_IDX) state_d = S_IDLE;
         end
         S_LOADEXP: if (s_fire) begin
            exp_d   = s_data[15:0];
            state_d = S_IDLE;
         end
         S_RUN: if (core_done) begin
            out_d   = core_result;
            cnt_d   = 5'd0;
            state_d = S_DRAIN;
         end
         S_DRAIN: if (m_fire) begin
            out_d = out_q >> WORD_W;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_IDX) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         tgt_q    <= 2'd0;
         msg_q    <= '0;
         n_q      <= '0;
         rmodn_q  <= '0;
         r2modn_q <= '0;
         out_q    <= '0;
         exp_q    <= 16'd0;
         mode_q   <= 1'b0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tgt_q    <= tgt_d;
         msg_q    <= msg_d;
         n_q      <= n_d;
         rmodn_q  <= rmodn_d;
         r2modn_q <= r2modn_d;
         out_q    <= out_d;
         exp_q    <= exp_d;
         mode_q   <= mode_d;
         start_q  <= start_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_rsa_word_frontend.sv
// Randomized scoreboard bench for rsa_word_frontend with an operand-array reference model and a stub core.
module tb_rsa_word_frontend;

   logic          clk = 1'b0;
   logic          resetn;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_data;
   logic          m_valid;
   logic          m_ready;
   logic [31:0]   m_data;
   logic          m_last;
   logic [1023:0] core_msg, core_n, core_rmodn, core_r2modn;
   logic [15:0]   core_exp;
   logic          core_encryp_mode;
   logic          core_start;
   logic          core_done;
   logic [1023:0] core_result;
   logic          busy;
   logic          err;
   logic          stub_done, man_done;

   assign core_done = stub_done | man_done;

   always #5 clk = ~clk;

   rsa_word_frontend #(.WORD_W(32), .OP_W(1024)) dut (
      .clk(clk), .resetn(resetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_msg(core_msg), .core_n(core_n), .core_rmodn(core_rmodn), .core_r2modn(core_r2modn),
      .core_exp(core_exp), .core_encryp_mode(core_encryp_mode), .core_start(core_start),
      .core_done(core_done), .core_result(core_result), .busy(busy), .err(err)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: operand word k of operand o, plus exponent/mode/err.
   logic [31:0] mdl [4][32];
   logic [15:0] mdl_exp;
   logic        mdl_mode, mdl_err;
   logic [32:0] exp_q [$];
   int          run_idx = 0;
   bit          tog = 1'b0;
   int          acc_cnt = 0, stall_cnt = 0, start_cnt = 0;

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic flag_fail(input string name);
      n_chk++;
      $display("FAIL %s: condition not met", name);
   endtask

   function automatic logic [1023:0] op_val(input int o);
      logic [1023:0] v;
      for (int k = 0; k < 32; k++) v[32*k +: 32] = mdl[o][k];
      return v;
   endfunction

   task automatic clear_model();
      for (int o = 0; o < 4; o++)
         for (int k = 0; k < 32; k++) mdl[o][k] = 32'd0;
      mdl_exp = 16'd0; mdl_mode = 1'b0; mdl_err = 1'b0;
   endtask

   task automatic check_ops(input string tag);
      chk({tag, "_msg"},    core_msg,    op_val(0));
      chk({tag, "_n"},      core_n,      op_val(1));
      chk({tag, "_rmodn"},  core_rmodn,  op_val(2));
      chk({tag, "_r2modn"}, core_r2modn, op_val(3));
      chk({tag, "_exp"},    core_exp,    mdl_exp);
      chk({tag, "_mode"},   core_encryp_mode, mdl_mode);
      chk({tag, "_err"},    err,         mdl_err);
   endtask

   always @(posedge clk) if (resetn) begin
      if (s_valid && s_ready)  acc_cnt++;
      if (s_valid && !s_ready) stall_cnt++;
   end

   // Monitor: pops the scoreboard on each output transfer; a stalled word must equal the queue head.
   always @(negedge clk) begin
      if (resetn) begin
         if (core_start) start_cnt++;
         if (m_valid) begin
            if (exp_q.size() == 0) flag_fail("unexpected_m_valid");
            else if (m_ready) chk("result_word", {m_last, m_data}, exp_q.pop_front());
            else chk("stall_hold", {m_last, m_data}, exp_q[0]);
         end
      end
   end

   // Stub core: done 10 cycles after start; first run returns word k = ~k, later runs random.
   initial begin
      logic [1023:0] res;
      logic [31:0]   w, kk;
      stub_done = 1'b0;
      core_result = '0;
      forever begin
         @(negedge clk);
         if (resetn && core_start) begin
            for (int k = 0; k < 32; k++) begin
               kk = 32'(k);
               w = (run_idx == 0) ? ~kk : $urandom;
               res[32*k +: 32] = w;
               exp_q.push_back({(k == 31), w});
            end
            run_idx++;
            repeat (10) @(posedge clk);
            #1 core_result = res; stub_done = 1'b1;
            @(posedge clk);
            #1 stub_done = 1'b0; core_result = {32{$urandom}};
         end
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 m_ready = tog ? ~m_ready : 1'b1;
      end
   end

   // All stimulus tasks start and end at 1 time unit after a rising edge.
   task automatic send(input logic [31:0] d);
      int g = 0;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      while (!s_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (!s_ready) flag_fail("send_timeout");
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic hdr(input logic [2:0] op, input logic mode);
      logic [31:0] d;
      d = $urandom;
      d[3:0] = {mode, op};
      send(d);
      if (op == 3'd5) begin mdl_mode = mode; mdl_err = 1'b0; end
      if (op >= 3'd6) mdl_err = 1'b1;
   endtask

   task automatic load_frame(input int op, input bit pat, input int done_at);
      logic [31:0] w;
      hdr(3'(op), 1'b0);
      for (int k = 0; k < 32; k++) begin
         if (k == done_at) begin
            man_done = 1'b1;
            @(posedge clk);
            #1 man_done = 1'b0;
            @(negedge clk);
            chk("done_in_load_mvalid", m_valid, 1'b0);
            chk("done_in_load_busy", busy, 1'b1);
            @(posedge clk);
            #1;
         end
         w = pat ? 32'h1000_0000 + 32'(k) : $urandom;
         send(w);
         mdl[op][k] = w;
      end
   endtask

   task automatic wait_idle(output int mv, output bit sr);
      int c = 0;
      mv = 0; sr = 1'b0;
      do begin
         @(negedge clk);
         c++;
         if (m_valid) mv++;
         if (busy && s_ready) sr = 1'b1;
      end while (busy && c < 3000);
      if (busy) flag_fail("wait_idle_timeout");
   endtask

   initial begin
      int mv, a0, s0, sc;
      bit sr;
      resetn = 1'b0; s_valid = 1'b0; s_data = 32'd0; man_done = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b1);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_core_start", core_start, 1'b0);
      check_ops("rst");
      @(posedge clk);
      #1;

      // MSG ramp pattern: 33 accepted cycles with no stall
      a0 = acc_cnt; s0 = stall_cnt;
      load_frame(0, 1'b1, -1);
      chk("msg_accept_cycles", acc_cnt - a0, 33);
      chk("msg_no_stall", stall_cnt - s0, 0);
      chk("msg_word5", core_msg[32*5 +: 32], 32'h1000_0005);
      check_ops("msg");

      for (int o = 1; o < 4; o++) load_frame(o, 1'b0, -1);
      check_ops("ops");
      hdr(3'd4, 1'b0);
      send(32'hABCD_0011);
      mdl_exp = 16'h0011;
      chk("exp_value", core_exp, 16'h0011);

      // START mode 1, toggling m_ready
      tog = 1'b1; sc = start_cnt;
      hdr(3'd5, 1'b1);
      chk("start_pulse", core_start, 1'b1);
      chk("start_busy", busy, 1'b1);
      chk("start_mode", core_encryp_mode, 1'b1);
      @(posedge clk);
      #1 chk("start_single", core_start, 1'b0);
      wait_idle(mv, sr);
      chk("s_ready_low_run", sr, 1'b0);
      chk("s_ready_after_drain", s_ready, 1'b1);
      chk("start_count", start_cnt - sc, 1);
      chk("queue_drained1", exp_q.size(), 0);
      tog = 1'b0;
      @(posedge clk);
      #1;

      // illegal header, then START clears err; full-rate drain
      hdr(3'd7, 1'b0);
      chk("illegal_err", err, 1'b1);
      chk("illegal_idle", busy, 1'b0);
      hdr(3'd5, 1'b0);
      chk("start_clears_err", err, 1'b0);
      wait_idle(mv, sr);
      chk("drain_32_cycles", mv, 32);
      chk("queue_drained2", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // MSG reload with core_done during LOAD, then core_done in IDLE
      load_frame(0, 1'b0, 5);
      man_done = 1'b1;
      @(posedge clk);
      #1 man_done = 1'b0;
      @(negedge clk);
      chk("done_in_idle_mvalid", m_valid, 1'b0);
      chk("done_in_idle_busy", busy, 1'b0);
      check_ops("reload");
      @(posedge clk);
      #1;

      // reset after 12 words of an N frame
      hdr(3'd1, 1'b0);
      for (int k = 0; k < 12; k++) send($urandom);
      resetn = 1'b0;
      @(posedge clk);
      #1 clear_model();
      chk("midrst_core_n", core_n, 1024'd0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_s_ready", s_ready, 1'b1);
      check_ops("midrst");
      resetn = 1'b1;
      load_frame(1, 1'b0, -1);
      check_ops("after_rst");

      // run abandoned by reset; stub done then arrives in IDLE
      hdr(3'd5, 1'b1);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      clear_model();
      exp_q.delete();
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("abandon_mvalid", m_valid, 1'b0);
      chk("abandon_busy", busy, 1'b0);
      check_ops("abandon");
      @(posedge clk);
      #1;

      // final random run with stalls
      for (int o = 0; o < 4; o++) load_frame(o, 1'b0, -1);
      tog = 1'b1;
      hdr(3'd5, 1'b0);
      wait_idle(mv, sr);
      chk("queue_drained3", exp_q.size(), 0);
      check_ops("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
